ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage: holds the program counter, issues in-order word requests to instruction memory, and buffers returned instructions with their PC. It presents them through a valid/ready handshake to the `id` decoder downstream. It accepts a redirect from execute (branch/jump), and on redirect flushes buffered and in-flight fetches.

## Interface
- `INSTRUCTON_WIDTH`, 32, instruction word width (matches `id`)
- `ADDR_WIDTH`, 32, PC / memory address width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `FIFO_DEPTH`, 2, instruction buffer entries; power of two, ≥2

- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `imem_req_valid` out 1: fetch request
- `imem_req_ready` in 1: memory accepts request
- `imem_req_addr` out ADDR_WIDTH: word-aligned fetch address
- `imem_rsp_valid` in 1: response strobe; in order, ≥1 cycle after its request, always accepted
- `imem_rsp_data` in INSTRUCTON_WIDTH: fetched word
- `redirect_valid` in 1: one-cycle PC redirect
- `redirect_pc` in ADDR_WIDTH: new PC; bits [1:0] ignored (forced 0)
- `out_valid` out 1: instruction available to `id`
- `out_ready` in 1: `id` accepts
- `out_instruction` out INSTRUCTON_WIDTH: to `id.input_instruction`
- `out_pc` out ADDR_WIDTH: PC of `out_instruction`

## Operation
- States:
  - IDLE: one cycle after reset release, no requests; then → RUN.
  - RUN: normal fetch.
  - FLUSH: `drop_cnt` > 0.
  - FLUSH → RUN when `drop_cnt` reaches 0 with no new redirect.
  - Any state → FLUSH on redirect if in-flight count (after this cycle's handshakes) > 0; otherwise → RUN.
- Credit rule: `imem_req_valid` = (state ≠ IDLE) && (`inflight` + `fifo_count` < FIFO_DEPTH). Requests are issued in FLUSH too; dropped fetches still hold credits until their response arrives.
- Request handshake (valid && ready): `pc` ← `pc` + 4, `inflight` += 1, and the address is pushed to an internal address queue (depth FIFO_DEPTH).
- Response:
  - `inflight` −= 1 and the address queue is popped.
  - If `drop_cnt` > 0: data discarded, `drop_cnt` −= 1.
  - Otherwise {address, data} is pushed to the instruction FIFO.
- Redirect:
  - `pc` ← {`redirect_pc`[ADDR_WIDTH-1:2], 2'b00}.
  - Instruction FIFO cleared.
  - `drop_cnt` ← `inflight` after this cycle's request/response updates. A request handshaken in the redirect cycle carries the old PC and is dropped. A response in the redirect cycle is discarded.
  - Redirect overrides the `pc`+4 increment.
- Output:
  - `out_valid` = FIFO non-empty && !`redirect_valid`. A pop in a redirect cycle never occurs.
  - Pop on `out_valid` && `out_ready`.
- PC arithmetic is modulo 2^ADDR_WIDTH; 0xFFFF_FFFC + 4 wraps to 0.
- Counters `inflight`, `drop_cnt`, `fifo_count` are $clog2(FIFO_DEPTH)+1 bits and never exceed FIFO_DEPTH.

## Timing
- Reset values:
  - `pc`/`imem_req_addr` = RESET_PC, state = IDLE, all counters 0, FIFO empty.
  - `imem_req_valid` = 0, `out_valid` = 0, `out_instruction` = 0, `out_pc` = 0.
- First `imem_req_valid` = 1 in the second cycle after `rst` deasserts.
- `imem_req_addr` is registered; `imem_req_valid` is combinational from registers only (no input-to-output path).
- Response to `out_valid`: 1 cycle (FIFO write, then read). This is 0 cycles with bypass (see Configuration).
- Redirect in cycle N: the first request at `redirect_pc` is presented in cycle N+1 if credit allows.
- `rst` mid-transaction: all state cleared immediately. Memory responses after reset are not expected; the memory is reset with the core.
- Full FIFO with `out_ready` = 0: no new requests; occupancy plus in-flight never overruns.

## Configuration
- `IFETCH_BYPASS_EN` defined:
  - When the FIFO is empty, `drop_cnt` = 0 and no redirect, an arriving response drives `out_valid`/`out_instruction`/`out_pc` combinationally in the same cycle.
  - If `out_ready` = 1 it is not written to the FIFO.
- Undefined: every instruction passes through the FIFO; outputs depend only on registers plus `redirect_valid`.

## Structure
- `ifetch_pkg`:
  - state enum `ifetch_state_t` {IDLE, RUN, FLUSH}
  - `INSN_BYTES` = 4
  - typedef `fetch_entry_t` {addr, insn}
- Sub-module `ifetch_fifo`:
  - synchronous FIFO of `fetch_entry_t`, depth FIFO_DEPTH
  - push/pop/flush ports, `count` output
  - also used for the address queue
- Top level holds the PC, credit logic, state machine, and drop counter.

## Test plan
- Reset release, `imem_req_ready` = 1, memory latency 1, `out_ready` = 1 → requests at 0x0, 0x4, 0x8…; `out_pc` follows the same sequence with matching data; the first request is in cycle 2.
- `out_ready` = 0 for 10 cycles → exactly 2 requests issued (FIFO_DEPTH = 2), `imem_req_valid` then 0; releasing `out_ready` resumes at 0x8.
- Latency 3, 2 in flight, redirect to 0x100 → both stale responses discarded, next `out_pc` = 0x100, no 0x0/0x4 instruction output.
- Redirect to 0x203 in the same cycle as a request handshake at 0x10 → next request address 0x200; the 0x10 response is dropped.
- `RESET_PC` = 0xFFFF_FFFC → second request address 0x0.
- With `IFETCH_BYPASS_EN`, empty FIFO, response 0x00500093 at PC 0x0 → `out_valid` = 1 in the same cycle with `out_instruction` = 0x00500093.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, the buffered
// {address, instruction} entry, and the instruction size in bytes.
package ifetch_pkg;

    localparam int INSN_BYTES   = 4;
    localparam int ENTRY_ADDR_W = 32;
    localparam int ENTRY_INSN_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } ifetch_state_t;

    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] addr;
        logic [ENTRY_INSN_W-1:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush; used both as the
// instruction buffer and as the in-flight address queue.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output fetch_entry_t           head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW:0]      count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
        end
    end

    // NOTE: storage has no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC, credit-limited in-order requests, response buffer
// and redirect flush. Define IFETCH_BYPASS_EN to forward a response straight
// to the output when the buffer is empty.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int                    INSTRUCTON_WIDTH = 32,
    parameter int                    ADDR_WIDTH       = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC         = '0,
    parameter int                    FIFO_DEPTH       = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        imem_req_valid,
    input  logic                        imem_req_ready,
    output logic [ADDR_WIDTH-1:0]       imem_req_addr,
    input  logic                        imem_rsp_valid,
    input  logic [INSTRUCTON_WIDTH-1:0] imem_rsp_data,
    input  logic                        redirect_valid,
    input  logic [ADDR_WIDTH-1:0]       redirect_pc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [INSTRUCTON_WIDTH-1:0] out_instruction,
    output logic [ADDR_WIDTH-1:0]       out_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ifetch_state_t         state_q;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]         drop_q, drop_d;
    logic [CW-1:0]         inflight, inflight_d;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           credit_sum;
    fetch_entry_t          aq_head, aq_push_data, fifo_head, fifo_push_data;
    logic                  req_fire, fifo_empty, fifo_push, fifo_pop, bypass_hit;

    // The address queue occupancy is exactly the number of fetches in flight.
    ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_addr_q (
        .clk         (clk),
        .rst         (rst),
        .push_i      (req_fire),
        .push_data_i (aq_push_data),
        .pop_i       (imem_rsp_valid),
        .flush_i     (1'b0),
        .head_o      (aq_head),
        .count_o     (inflight)
    );

    ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_insn_q (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (fifo_push_data),
        .pop_i       (fifo_pop),
        .flush_i     (redirect_valid),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign credit_sum     = {1'b0, inflight} + {1'b0, fifo_count};
    assign imem_req_valid = (state_q != IDLE) && (credit_sum < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign aq_push_data   = '{addr: ENTRY_ADDR_W'(pc_q), insn: '0};
    assign fifo_empty     = (fifo_count == '0);

`ifdef IFETCH_BYPASS_EN
    assign bypass_hit = imem_rsp_valid && fifo_empty && (drop_q == '0) && !redirect_valid;
`else
    assign bypass_hit = 1'b0;
`endif

    assign out_valid = (!fifo_empty || bypass_hit) && !redirect_valid;
    assign fifo_pop  = out_valid && out_ready && !fifo_empty;
    assign fifo_push = imem_rsp_valid && (drop_q == '0) && !redirect_valid
                       && !(bypass_hit && out_ready);

    always_comb begin
        fifo_push_data      = aq_head;
        fifo_push_data.insn = ENTRY_INSN_W'(imem_rsp_data);
    end

    always_comb begin
        out_instruction = '0;
        out_pc          = '0;
        if (bypass_hit) begin
            out_instruction = imem_rsp_data;
            out_pc          = ADDR_WIDTH'(aq_head.addr);
        end else if (!fifo_empty) begin
            out_instruction = INSTRUCTON_WIDTH'(fifo_head.insn);
            out_pc          = ADDR_WIDTH'(fifo_head.addr);
        end
    end

    // Redirect wins over the sequential increment; fetches still in flight
    // after this cycle's handshakes become the drop count.
    always_comb begin
        inflight_d = inflight + CW'(req_fire) - CW'(imem_rsp_valid);
        pc_d       = pc_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            pc_d   = redirect_pc & ~ADDR_WIDTH'(INSN_BYTES - 1);
            drop_d = inflight_d;
        end else begin
            if (req_fire) pc_d = pc_q + ADDR_WIDTH'(INSN_BYTES);
            if (imem_rsp_valid && drop_q != '0) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            drop_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
            if (redirect_valid) begin
                state_q <= (inflight_d != '0) ? FLUSH : RUN;
            end else begin
                case (state_q)
                    IDLE:    state_q <= RUN;
                    FLUSH:   if (drop_d == '0) state_q <= RUN;
                    default: state_q <= state_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: a latency-programmable memory model queues
// expected {pc, insn} pairs which are compared as the stage hands them out.
module tb_ifetch;

    localparam int AW = 32;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic          redirect_valid, out_valid, out_ready;
    logic [AW-1:0] imem_req_addr, redirect_pc, out_pc;
    logic [IW-1:0] imem_rsp_data, out_instruction;
    logic          w_req_valid, w_out_valid;
    logic [AW-1:0] w_req_addr, w_out_pc;
    logic [IW-1:0] w_out_instruction;

    always #5 clk = ~clk;

    ifetch dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc)
    );

    ifetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (w_req_valid),
        .imem_req_ready  (1'b1),
        .imem_req_addr   (w_req_addr),
        .imem_rsp_valid  (1'b0),
        .imem_rsp_data   ('0),
        .redirect_valid  (1'b0),
        .redirect_pc     ('0),
        .out_valid       (w_out_valid),
        .out_ready       (1'b1),
        .out_instruction (w_out_instruction),
        .out_pc          (w_out_pc)
    );

    typedef struct { logic [AW-1:0] addr; int due; bit stale; } mreq_t;
    typedef struct { logic [AW-1:0] pc; logic [IW-1:0] insn; } exp_t;

    mreq_t         mq[$];
    exp_t          expq[$];
    logic [AW-1:0] req_log[$];
    logic [AW-1:0] out_log[$];
    int            cycle, lat, vectors, miscompares;
    logic          tb_ready, tb_out_ready, tb_redirect;
    logic [AW-1:0] tb_redirect_pc, exp_pc;
    logic          redir_arm, redir_done;
    logic [AW-1:0] redir_match, redir_target;
    logic          last_rv, last_ov;
    logic [IW-1:0] last_oi;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == '0) return 32'h0050_0093;
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic clear_model();
        mq.delete(); expq.delete(); req_log.delete(); out_log.delete();
        redir_arm = 1'b0; redir_done = 1'b0; tb_redirect = 1'b0;
        tb_ready = 1'b0; tb_out_ready = 1'b0; tb_redirect_pc = '0;
        exp_pc = '0; cycle = 0; lat = 1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle: drive inputs at the falling edge, observe, update model.
    task automatic step();
        mreq_t         cur;
        exp_t          e;
        logic          rv, redir, rsp_now;
        logic [AW-1:0] ra;
        @(negedge clk);
        rv    = imem_req_valid;
        ra    = imem_req_addr;
        redir = tb_redirect;
        if (redir_arm && rv && tb_ready && ra == redir_match) begin
            redir          = 1'b1;
            tb_redirect_pc = redir_target;
            redir_arm      = 1'b0;
            redir_done     = 1'b1;
        end
        imem_req_ready = tb_ready;
        out_ready      = tb_out_ready;
        redirect_valid = redir;
        redirect_pc    = tb_redirect_pc;
        rsp_now        = 1'b0;
        cur            = '{addr: '0, due: 0, stale: 1'b0};
        if (mq.size() > 0 && mq[0].due <= cycle) begin
            cur     = mq.pop_front();
            rsp_now = 1'b1;
        end
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? mem_word(cur.addr) : '0;
        #1;
        last_rv = rv;
        last_ov = out_valid;
        last_oi = out_instruction;
        if (rsp_now && !cur.stale && !redir)
            expq.push_back('{pc: cur.addr, insn: mem_word(cur.addr)});
        if (redir) begin
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL out_valid_in_redirect: got %b, required 0", out_valid);
            end
        end else if (out_valid && out_ready) begin
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("FAIL out_unexpected: got pc=%h insn=%h, required no output", out_pc, out_instruction);
            end else begin
                e = expq.pop_front();
                if (out_pc !== e.pc || out_instruction !== e.insn) begin
                    miscompares++;
                    $display("FAIL out_entry: got pc=%h insn=%h, required pc=%h insn=%h",
                             out_pc, out_instruction, e.pc, e.insn);
                end
            end
            out_log.push_back(out_pc);
        end
        if (rv && tb_ready) begin
            vectors++;
            if (ra !== exp_pc) begin
                miscompares++;
                $display("FAIL req_addr: got %h, required %h", ra, exp_pc);
            end
            mq.push_back('{addr: ra, due: cycle + lat, stale: 1'b0});
            req_log.push_back(ra);
            exp_pc = exp_pc + 32'd4;
        end
        if (redir) begin
            foreach (mq[i]) mq[i].stale = 1'b1;
            expq.delete(); req_log.delete(); out_log.delete();
            exp_pc = tb_redirect_pc & ~32'h3;
        end
        cycle++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        @(negedge clk);
        #1;
        vectors++;
        if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valids: got req=%b out=%b, required 0 0", imem_req_valid, out_valid);
        end
        vectors++;
        if (imem_req_addr !== 32'h0 || out_pc !== 32'h0 || out_instruction !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_values: got addr=%h pc=%h insn=%h, required 0 0 0",
                     imem_req_addr, out_pc, out_instruction);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (imem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_cycle_req: got %b, required 0", imem_req_valid);
        end
        tb_ready = 1'b1; tb_out_ready = 1'b1;
        step();
        vectors++;
        if (last_rv !== 1'b1) begin
            miscompares++;
            $display("FAIL first_req_cycle2: got %b, required 1", last_rv);
        end
    endtask

    task automatic test_stream();
        int bad;
        apply_reset();
        tb_ready = 1'b1; tb_out_ready = 1'b1; lat = 1;
        repeat (30) step();
        vectors++;
        if (out_log.size() < 12) begin
            miscompares++;
            $display("FAIL stream_count: got %0d outputs, required at least 12", out_log.size());
        end
        bad = 0;
        foreach (out_log[i]) if (out_log[i] !== 32'(4 * i)) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL stream_order: got %0d out-of-sequence pcs, required 0", bad);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        tb_ready = 1'b1; tb_out_ready = 1'b0; lat = 1;
        repeat (10) step();
        vectors++;
        if (req_log.size() != 2) begin
            miscompares++;
            $display("FAIL stall_req_count: got %0d, required 2", req_log.size());
        end
        vectors++;
        if (last_rv !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_req_valid: got %b, required 0", last_rv);
        end
        tb_out_ready = 1'b1;
        repeat (10) step();
        vectors++;
        if (req_log.size() < 3 || req_log[2] !== 32'h8) begin
            miscompares++;
            $display("FAIL resume_addr: got %0d requests, required third at 00000008", req_log.size());
        end
        vectors++;
        if (out_log.size() < 2 || out_log[0] !== 32'h0 || out_log[1] !== 32'h4) begin
            miscompares++;
            $display("FAIL resume_outputs: got %0d outputs, required 0 then 4 first", out_log.size());
        end
    endtask

    task automatic test_redirect_flush();
        apply_reset();
        tb_ready = 1'b1; tb_out_ready = 1'b1; lat = 3;
        step();
        step();
        vectors++;
        if (req_log.size() != 2) begin
            miscompares++;
            $display("FAIL flush_inflight: got %0d requests, required 2", req_log.size());
        end
        tb_redirect = 1'b1; tb_redirect_pc = 32'h100;
        step();
        tb_redirect = 1'b0;
        repeat (20) step();
        vectors++;
        if (out_log.size() == 0 || out_log[0] !== 32'h100) begin
            miscompares++;
            $display("FAIL flush_first_out: got %0d outputs, required first pc 00000100", out_log.size());
        end
        vectors++;
        if (req_log.size() == 0 || req_log[0] !== 32'h100) begin
            miscompares++;
            $display("FAIL flush_first_req: got %0d requests, required first 00000100", req_log.size());
        end
    endtask

    task automatic test_redirect_same_cycle();
        int n;
        apply_reset();
        tb_ready = 1'b1; tb_out_ready = 1'b1; lat = 1;
        redir_arm = 1'b1; redir_match = 32'h10; redir_target = 32'h203;
        n = 0;
        while (!redir_done && n < 40) begin
            step();
            n++;
        end
        vectors++;
        if (redir_done !== 1'b1) begin
            miscompares++;
            $display("FAIL same_cycle_timeout: request at 00000010 not seen in %0d cycles", n);
        end
        repeat (15) step();
        vectors++;
        if (req_log.size() == 0 || req_log[0] !== 32'h200) begin
            miscompares++;
            $display("FAIL same_cycle_req: got %0d requests, required first 00000200", req_log.size());
        end
        vectors++;
        if (out_log.size() == 0 || out_log[0] !== 32'h200) begin
            miscompares++;
            $display("FAIL same_cycle_out: got %0d outputs, required first pc 00000200", out_log.size());
        end
    endtask

    task automatic test_reset_pc_wrap();
        apply_reset();
        #1;
        vectors++;
        if (w_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_idle: got %b, required 0", w_req_valid);
        end
        step();
        vectors++;
        if (w_req_valid !== 1'b1 || w_req_addr !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_first: got v=%b addr=%h, required 1 fffffffc", w_req_valid, w_req_addr);
        end
        step();
        vectors++;
        if (w_req_valid !== 1'b1 || w_req_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_second: got v=%b addr=%h, required 1 00000000", w_req_valid, w_req_addr);
        end
        step();
        vectors++;
        if (w_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_credit: got %b, required 0", w_req_valid);
        end
        vectors++;
        if (w_out_valid !== 1'b0 || w_out_pc !== 32'h0 || w_out_instruction !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_no_output: got v=%b pc=%h insn=%h, required 0 0 0",
                     w_out_valid, w_out_pc, w_out_instruction);
        end
    endtask

    task automatic test_first_word();
        apply_reset();
        tb_ready = 1'b1; tb_out_ready = 1'b1; lat = 1;
        step();
        step();
`ifdef IFETCH_BYPASS_EN
        vectors++;
        if (last_ov !== 1'b1 || last_oi !== 32'h0050_0093) begin
            miscompares++;
            $display("FAIL bypass_same_cycle: got v=%b insn=%h, required 1 00500093", last_ov, last_oi);
        end
`else
        vectors++;
        if (last_ov !== 1'b0) begin
            miscompares++;
            $display("FAIL buffered_rsp_cycle: got %b, required 0", last_ov);
        end
        step();
        vectors++;
        if (last_ov !== 1'b1 || last_oi !== 32'h0050_0093) begin
            miscompares++;
            $display("FAIL buffered_next_cycle: got v=%b insn=%h, required 1 00500093", last_ov, last_oi);
        end
`endif
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        clear_model();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_redirect_same_cycle();
        test_reset_pc_wrap();
        test_first_word();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
